// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving ps2c/ps2d open-drain via output enables
// ports: clk, reset (sync, active-high), start/data (command request, byte), ps2c_in/ps2d_in (raw pins),
// ps2c_oe/ps2d_oe (1 = pull low), busy, done (end pulse), nack (no ACK or timeout), rx_block (= busy)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       rx_block
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, FIN} state_t;
  state_t state, nxt;
  logic [1:0] s1, s2, f;
  logic [FW-1:0] fc [2];
  logic c_d, fall_c, tmo, d_oe_n, nack_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bitcnt, bit_n;
  logic [9:0] sr, sr_n;
  // bit 0 = clock line, bit 1 = data line; a new level is taken only after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 2'b11;
      s2  <= 2'b11;
      f   <= 2'b11;
      c_d <= 1'b1;
      fc  <= '{default: '0};
    end else begin
      s1  <= {ps2d_in, ps2c_in};
      s2  <= s1;
      c_d <= f[0];
      for (int i = 0; i < 2; i++)
        if (s2[i] == f[i]) fc[i] <= '0;
        else if (fc[i] == FW'(FILTER_LEN - 1)) begin
          f[i]  <= s2[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 1'b1;
    end
  end
  assign fall_c = c_d & ~f[0];
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    bit_n  = bitcnt;
    sr_n   = sr;
    d_oe_n = ps2d_oe;
    nack_n = nack;
    case (state)
      IDLE: begin
        d_oe_n = 1'b0;
        cnt_n  = '0;
        if (start) begin
          sr_n   = {1'b1, ~^data, data};
          nack_n = 1'b0;
          nxt    = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          nxt    = RTS;
          d_oe_n = 1'b1;
        end
      end
      RTS: begin
        cnt_n = '0;
        bit_n = '0;
        nxt   = SEND;
      end
      SEND, ACK, WAIT_IDLE: begin
        cnt_n = fall_c ? '0 : cnt + 1'b1;
        // a device edge coinciding with terminal count keeps the transfer alive
        if (!fall_c && tmo) begin
          nxt    = FIN;
          d_oe_n = 1'b0;
          nack_n = 1'b1;
        end else if (state == SEND) begin
          if (fall_c) begin
            bit_n = bitcnt == 4'd11 ? bitcnt : bitcnt + 4'd1;
            if (bitcnt == 4'd10) nxt = ACK;
            else begin
              d_oe_n = ~sr[0];
              sr_n   = {1'b1, sr[9:1]};
            end
          end
        end else if (state == ACK) begin
          nack_n = f[1];
          nxt    = WAIT_IDLE;
        end else if (f[0] && f[1]) nxt = FIN;
      end
      default: begin
        cnt_n = '0;
        nxt   = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      sr      <= '0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      bitcnt  <= bit_n;
      sr      <= sr_n;
      ps2c_oe <= nxt == INHIBIT || nxt == RTS;
      ps2d_oe <= d_oe_n;
      busy    <= nxt != IDLE && nxt != FIN;
      done    <= nxt == FIN;
      nack    <= nack_n;
    end
  end
  assign rx_block = busy;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
  localparam int INH  = 500;
  localparam int TMO  = 4000;
  localparam int FL   = 4;
  localparam int HALF = 200;
  logic clk = 1'b0;
  logic reset, start, dev_c, dev_d;
  logic [7:0] data;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy, done, nack, rx_block;
  int checks = 0, fails = 0;
  int cyc = 0, inh_len = 0, rts_len = 0, send_cyc = -1, n_done = 0, done_cyc = 0;
  int busy_drop = 0, rxb_err = 0, last_fall = 0;
  logic done_nack = 1'b0;
  logic [1:0] done_oe = 2'b00;
  bit active = 0, prev_c = 0, prev_b = 0;
  bit exp_q[$];
  bit got[$];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .busy(busy), .done(done), .nack(nack), .rx_block(rx_block)
  );

  always #5 clk = ~clk;
  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) active = 0;
    else begin
      if (busy && !prev_b) begin
        inh_len = 0; rts_len = 0; send_cyc = -1; n_done = 0; busy_drop = 0; active = 1;
      end
      if (ps2c_oe && !ps2d_oe) inh_len++;
      if (ps2c_oe && ps2d_oe) rts_len++;
      if (prev_c && !ps2c_oe && send_cyc < 0) send_cyc = cyc;
      if (done) begin
        n_done++; done_cyc = cyc; done_nack = nack; done_oe = {ps2c_oe, ps2d_oe}; active = 0;
      end else if (active && !busy) busy_drop++;
    end
    if (rx_block !== busy) rxb_err++;
    prev_c = ps2c_oe;
    prev_b = busy;
  end

  task automatic push_exp(input logic [7:0] b, input int nclk);
    logic [10:0] fr;
    fr = {1'b1, ~^b, b, 1'b0};
    exp_q.delete();
    got.delete();
    for (int k = 0; k < nclk; k++) exp_q.push_back(fr[k]);
  endtask

  task automatic dev_run(input int nclk, input bit ack, input bit glitch);
    int t;
    t = 0;
    while (!ps2c_oe && t < 100) begin @(negedge clk); t++; end
    while (ps2c_oe && t < INH + 200) begin @(negedge clk); t++; end
    checks++;
    if (ps2c_oe !== 1'b0) begin
      fails++;
      $display("FAIL dev_wait_release ps2c_oe=%b required=0", ps2c_oe);
    end
    repeat (50) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (glitch && k == 3)
        repeat (2) begin
          dev_c = 1'b0; repeat (2) @(negedge clk);
          dev_c = 1'b1; repeat (20) @(negedge clk);
        end
      got.push_back(ps2d_in);
      if (k == 11 && ack) begin dev_d = 1'b0; repeat (2) @(negedge clk); end
      dev_c = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_d = 1'b1;
  endtask

  task automatic run_tx(input logic [7:0] b, input int nclk, input bit ack, input bit glitch, input bit poke);
    push_exp(b, nclk);
    @(negedge clk);
    start = 1'b1; data = b;
    @(negedge clk);
    start = 1'b0; data = ~b;
    fork
      dev_run(nclk, ack, glitch);
      if (poke) begin
        repeat (100) @(negedge clk);
        start = 1'b1; data = 8'h00;
        @(negedge clk);
        start = 1'b0;
      end
      for (int i = 0; i < 20000 && n_done == 0; i++) @(negedge clk);
    join
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; data = 8'h00; dev_c = 1'b1; dev_d = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, busy, done, nack, rx_block} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b required=000000", {ps2c_oe, ps2d_oe, busy, done, nack, rx_block});
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, busy, done, nack} !== 5'b0) begin
      fails++;
      $display("FAIL idle_outputs got=%b required=00000", {ps2c_oe, ps2d_oe, busy, done, nack});
    end
  endtask

  task automatic test_ack;
    run_tx(8'hED, 11, 1, 0, 0);
    checks++;
    if (inh_len != INH) begin fails++; $display("FAIL inhibit_len got=%0d required=%0d", inh_len, INH); end
    checks++;
    if (rts_len != 1) begin fails++; $display("FAIL rts_len got=%0d required=1", rts_len); end
    checks++;
    if (got.size() != exp_q.size()) begin fails++; $display("FAIL ack_bitcount got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL ack_bit%0d got=%b required=%b", k, g, e); end
    end
    checks++;
    if (n_done != 1) begin fails++; $display("FAIL ack_done_count got=%0d required=1", n_done); end
    checks++;
    if (done_nack !== 1'b0) begin fails++; $display("FAIL ack_nack got=%b required=0", done_nack); end
    checks++;
    if (busy_drop != 0) begin fails++; $display("FAIL ack_busy_drop got=%0d required=0", busy_drop); end
  endtask

  task automatic test_nack;
    run_tx(8'h01, 11, 0, 0, 0);
    checks++;
    if (got.size() != exp_q.size()) begin fails++; $display("FAIL nack_bitcount got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL nack_bit%0d got=%b required=%b", k, g, e); end
    end
    checks++;
    if (n_done != 1 || done_nack !== 1'b1) begin
      fails++; $display("FAIL nack_done got=%0d/%b required=1/1", n_done, done_nack);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (nack !== 1'b1) begin fails++; $display("FAIL nack_hold got=%b required=1", nack); end
  endtask

  task automatic test_timeout_idle;
    run_tx(8'h5A, 0, 1, 0, 0);
    checks++;
    if (n_done != 1) begin fails++; $display("FAIL tmo0_done_count got=%0d required=1", n_done); end
    checks++;
    if (done_cyc - send_cyc != TMO) begin
      fails++; $display("FAIL tmo0_latency got=%0d required=%0d", done_cyc - send_cyc, TMO);
    end
    checks++;
    if (done_oe !== 2'b00 || done_nack !== 1'b1) begin
      fails++; $display("FAIL tmo0_release got=oe%b/nack%b required=oe00/nack1", done_oe, done_nack);
    end
  endtask

  task automatic test_timeout_mid;
    int d;
    run_tx(8'h96, 5, 1, 0, 0);
    d = done_cyc - last_fall;
    checks++;
    if (n_done != 1 || done_nack !== 1'b1) begin
      fails++; $display("FAIL tmo5_done got=%0d/%b required=1/1", n_done, done_nack);
    end
    checks++;
    if (d < TMO + FL + 1 || d > TMO + FL + 4) begin
      fails++; $display("FAIL tmo5_latency got=%0d required=%0d..%0d", d, TMO + FL + 1, TMO + FL + 4);
    end
    checks++;
    if (got.size() != 5) begin fails++; $display("FAIL tmo5_bitcount got=%0d required=5", got.size()); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL tmo5_bit%0d got=%b required=%b", k, g, e); end
    end
  endtask

  task automatic test_glitch;
    run_tx(8'hA5, 11, 1, 1, 0);
    checks++;
    if (got.size() != exp_q.size()) begin fails++; $display("FAIL glitch_bitcount got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL glitch_bit%0d got=%b required=%b", k, g, e); end
    end
    checks++;
    if (n_done != 1 || done_nack !== 1'b0) begin
      fails++; $display("FAIL glitch_done got=%0d/%b required=1/0", n_done, done_nack);
    end
  endtask

  task automatic test_busy_start;
    run_tx(8'h3C, 11, 1, 0, 1);
    checks++;
    if (inh_len != INH) begin fails++; $display("FAIL poke_inhibit_len got=%0d required=%0d", inh_len, INH); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL poke_bit%0d got=%b required=%b", k, g, e); end
    end
    checks++;
    if (n_done != 1 || done_nack !== 1'b0) begin
      fails++; $display("FAIL poke_done got=%0d/%b required=1/0", n_done, done_nack);
    end
  endtask

  task automatic test_reset_mid;
    push_exp(8'hED, 4);
    @(negedge clk);
    start = 1'b1; data = 8'hED;
    @(negedge clk);
    start = 1'b0;
    dev_run(4, 0, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, busy, done} !== 4'b0) begin
      fails++; $display("FAIL midreset_outputs got=%b required=0000", {ps2c_oe, ps2d_oe, busy, done});
    end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (n_done != 0) begin fails++; $display("FAIL midreset_done got=%0d required=0", n_done); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL midreset_bit%0d got=%b required=%b", k, g, e); end
    end
    run_tx(8'hFF, 11, 1, 0, 0);
    checks++;
    if (got.size() != exp_q.size()) begin fails++; $display("FAIL ff_bitcount got=%0d required=%0d", got.size(), exp_q.size()); end
    for (int k = 0; got.size() > 0 && exp_q.size() > 0; k++) begin
      bit e, g;
      e = exp_q.pop_front(); g = got.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL ff_bit%0d got=%b required=%b", k, g, e); end
    end
    checks++;
    if (n_done != 1 || done_nack !== 1'b0) begin
      fails++; $display("FAIL ff_done got=%0d/%b required=1/0", n_done, done_nack);
    end
  endtask

  task automatic test_rx_block;
    checks++;
    if (rxb_err != 0) begin fails++; $display("FAIL rx_block_mismatch_cycles got=%0d required=0", rxb_err); end
  endtask

  initial begin
    test_reset;
    test_ack;
    test_nack;
    test_timeout_idle;
    test_timeout_mid;
    test_glitch;
    test_busy_start;
    test_reset_mid;
    test_rx_block;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the outbound counterpart of the existing PS/2 scan-code receiver and sends command bytes to the keyboard, such as 0xED (set LEDs) and 0xFF (reset). It sits beside the receiver in the memory unit's I/O space and drives the shared ps2c/ps2d lines open-drain through output-enable signals. The top level converts each enable into "drive 0 / high-Z".

Parameters:
INHIBIT_CYCLES, 2500, cycles ps2c is held low before request-to-send (100 us at 25 MHz).
TIMEOUT_CYCLES, 375000, max cycles between device clock falling edges before abort (15 ms at 25 MHz).
FILTER_LEN, 4, consecutive equal synchronized samples required to accept a new ps2c/ps2d level.

Ports:
clk  in  1  system clock (25 MHz)
reset  in  1  synchronous, active-high
start  in  1  single-cycle request; accepted only when busy=0
data  in  8  command byte; sampled on the accepted start cycle
ps2c_in  in  1  raw PS/2 clock pin level
ps2d_in  in  1  raw PS/2 data pin level
ps2c_oe  out  1  1 = pull ps2c low
ps2d_oe  out  1  1 = pull ps2d low
busy  out  1  high from the cycle after accepted start until the cycle done pulses
done  out  1  one-cycle pulse at end of transaction (success or abort)
nack  out  1  valid with done and held until next accepted start; 1 = no ACK or timeout
rx_block  out  1  equals busy; receiver ignores the lines while high

Behaviour:
- Reset: ps2c_oe=0, ps2d_oe=0, busy=0, done=0, nack=0. State=IDLE, counters=0, filters preset to 1.
- Reset during a transfer releases both lines on the next edge. No done pulse is issued.
- Input conditioning:
  - 2-FF synchronizer per line, then a FILTER_LEN agreement filter.
  - fall_c = filtered ps2c goes 1->0.
  - Edge latency from the pin is 2+FILTER_LEN cycles.
- Parity: odd. par = ~^data.
- Frame shift register: {1(stop), par, data[7:0]}, LSB first. Latched on start.
- States:
  - IDLE: all oe=0. On start: latch frame, nack<=0 -> INHIBIT. start while busy is ignored.
  - INHIBIT: ps2c_oe=1, ps2d_oe=0 for exactly INHIBIT_CYCLES cycles -> RTS.
  - RTS: one cycle with ps2c_oe=1, ps2d_oe=1 (start bit 0) -> SEND. Clear bitcnt and timeout counter.
  - SEND: ps2c_oe=0.
    - Start bit is still driven (ps2d_oe=1) until the first fall_c.
    - On each fall_c: present the next frame bit, ps2d_oe = ~bit, bitcnt++.
    - The 10th fall_c presents the stop bit (ps2d_oe=0).
    - The 11th fall_c -> ACK.
  - ACK: on the 11th fall_c cycle, sample filtered ps2d: 0 = ACK, 1 = nack. -> WAIT_IDLE.
  - WAIT_IDLE: wait until filtered ps2c=1 and ps2d=1 -> FIN.
  - FIN: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE; it clears on every fall_c.
  - On reaching TIMEOUT_CYCLES: release both lines, nack=1 -> FIN.
- A fall_c arriving in the same cycle as the timeout terminal count takes priority: counter clears, no abort.
- Counter widths: ceil(log2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)) bits. bitcnt is 4 bits, saturating at 11.
- The device is never driven high. Outputs are registered.

Test Plan:
- Send 0xED with a device model clocking at ~12.5 kHz (1000-cycle half period) that ACKs. Required response:
  - ps2c_oe high exactly 2500 cycles, then a 1-cycle RTS.
  - Device samples 0,1,0,1,1,0,1,1,1,parity 1,stop 1.
  - done pulses once with nack=0; busy was high throughout.
- Send 0x01 (parity 0) with the device leaving ps2d high on the 11th clock -> device sees 0,1,0,0,0,0,0,0,0,0,1; done with nack=1.
- Device never clocks after RTS -> abort exactly TIMEOUT_CYCLES after entering SEND. Both oe=0 and done with nack=1.
- Device stops after 5 clocks -> abort TIMEOUT_CYCLES after the 5th fall_c, nack=1.
- 2-cycle glitch pulses on ps2c_in (shorter than FILTER_LEN) -> no bit advance.
- start asserted while busy is ignored; data changes after start do not alter the frame.
- Assert reset mid-SEND (after 4 bits) -> next cycle all oe=0, busy=0, no done.
  - A following start with 0xFF transmits a full, correct frame (parity 1).
